scoreboard_controller: RTL and testbench

- Game-level controller that owns the two-digit BCD score and the lives counter, and drives the scoreboard digit generator.
- Arbitrates score events from NREQ requesters using round-robin with a req/ack handshake, and applies one event per cycle.
- Sequences the game through four states: IDLE, PLAY, DYING and OVER. Timing is in video frames, taken from the rising edges of vsync.
- Replaces the free-running, edge-clocked stats counters with one synchronous clk-domain block.

---
 rtl/scoreboard_controller_pkg.sv | 21 ++
 rtl/scoreboard_controller_if.sv | 11 +
 rtl/scoreboard_controller_rr_arbiter.sv | 37 +++
 rtl/scoreboard_controller.sv | 140 ++++++++++++++
 tb/tb_scoreboard_controller.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_controller_pkg.sv
// Shared encodings and helpers for the scoreboard controller.
package scoreboard_controller_pkg;
  localparam int BCD_MAX = 9;
  localparam int FCNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic [3:0] clamp_pts(input logic [3:0] p);
    return (p > 4'(BCD_MAX)) ? 4'(BCD_MAX) : p;
  endfunction
endpackage

// File: rtl/scoreboard_controller_if.sv
// Score/die request handshake between requesters and the controller.
interface scoreboard_controller_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   score_req;
  logic [4*NREQ-1:0] score_pts;
  logic [NREQ-1:0]   score_ack;
  logic              die_req;
  logic              die_ack;

  modport master (output score_req, score_pts, die_req, input score_ack, die_ack);
  modport slave  (input score_req, score_pts, die_req, output score_ack, die_ack);
endinterface

// File: rtl/scoreboard_controller_rr_arbiter.sv
// Combinational round-robin picker; the pointer lives in the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_enable,
  output logic [N-1:0]  o_grant,
  output logic          o_grant_valid,
  output logic [PW-1:0] o_grant_index
);
  logic [N-1:0] w_elig;

  // A requester whose ack is still high is masked so a late deassert is not re-served.
  assign w_elig = i_req & ~i_mask;

  always_comb begin
    int j;
    j             = 0;
    o_grant       = '0;
    o_grant_valid = 1'b0;
    o_grant_index = '0;
    if (i_enable) begin
      for (int k = 0; k < N; k++) begin
        j = int'(i_ptr) + k;
        if (j >= N) j = j - N;
        if (!o_grant_valid && w_elig[j]) begin
          o_grant[j]    = 1'b1;
          o_grant_valid = 1'b1;
          o_grant_index = PW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/scoreboard_controller.sv
// Game state sequencer, BCD score keeper and lives counter with RR score arbitration.
module scoreboard_controller
  import scoreboard_controller_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_vsync,
  input  logic                    i_start,
  scoreboard_controller_if.slave  bus,
  output logic [3:0]              o_score0,
  output logic [3:0]              o_score1,
  output logic [3:0]              o_lives,
  output logic [1:0]              o_state,
  output logic                    o_play_en
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state, w_state_nxt;
  bcd2_t             r_score, w_score_nxt;
  logic [3:0]        r_lives, w_lives_nxt;
  logic [NREQ-1:0]   r_ack, w_ack_nxt;
  logic              r_die_ack, w_die_ack_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic              r_vsync_q;

  logic              w_tick, w_die_go, w_arb_en;
  logic [NREQ-1:0]   w_grant;
  logic              w_grant_valid;
  logic [PW-1:0]     w_grant_idx;
  logic [3:0]        w_pts;
  logic [4:0]        w_sum;

  assign w_tick   = i_vsync & ~r_vsync_q;
  assign w_die_go = (r_state == ST_PLAY) && bus.die_req && !r_die_ack;
  assign w_arb_en = (r_state == ST_PLAY) && !w_die_go;

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req         (bus.score_req),
    .i_mask        (r_ack),
    .i_ptr         (r_ptr),
    .i_enable      (w_arb_en),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_index (w_grant_idx)
  );

  assign w_pts = clamp_pts(bus.score_pts[4*w_grant_idx +: 4]);
  assign w_sum = {1'b0, r_score.ones} + {1'b0, w_pts};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_PLAY;
      ST_PLAY:  if (w_die_go) w_state_nxt = (r_lives == 4'd1) ? ST_OVER : ST_DYING;
      ST_DYING: if (w_tick && r_fcnt == FCNT_W'(DEATH_FRAMES - 1)) w_state_nxt = ST_PLAY;
      ST_OVER:  if (w_tick && r_fcnt == FCNT_W'(OVER_FRAMES - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;
    w_ack_nxt     = '0;
    w_die_ack_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_fcnt_nxt    = r_fcnt;
    if (w_state_nxt != r_state)
      w_fcnt_nxt = '0;
    else if (w_tick && (r_state == ST_DYING || r_state == ST_OVER))
      w_fcnt_nxt = r_fcnt + 1'b1;

    if (r_state == ST_IDLE && i_start) begin
      w_score_nxt = '0;
      w_lives_nxt = 4'(START_LIVES);
    end

    if (w_die_go) begin
      w_die_ack_nxt = 1'b1;
      w_lives_nxt   = r_lives - 4'd1;
    end else if (w_grant_valid) begin
      w_ack_nxt = w_grant;
      w_ptr_nxt = (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
      if (w_sum >= 5'd10) begin
        // Carry out of the tens digit pins the score at 99.
        if (r_score.tens == 4'(BCD_MAX)) begin
          w_score_nxt.tens = 4'(BCD_MAX);
          w_score_nxt.ones = 4'(BCD_MAX);
        end else begin
          w_score_nxt.ones = 4'(w_sum - 5'd10);
          w_score_nxt.tens = r_score.tens + 4'd1;
        end
      end else begin
        w_score_nxt.ones = w_sum[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score   <= '0;
      r_lives   <= 4'(START_LIVES);
      r_ack     <= '0;
      r_die_ack <= 1'b0;
      r_ptr     <= '0;
      r_fcnt    <= '0;
      r_vsync_q <= 1'b0;
    end else begin
      r_score   <= w_score_nxt;
      r_lives   <= w_lives_nxt;
      r_ack     <= w_ack_nxt;
      r_die_ack <= w_die_ack_nxt;
      r_ptr     <= w_ptr_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_vsync_q <= i_vsync;
    end
  end

  assign bus.score_ack = r_ack;
  assign bus.die_ack   = r_die_ack;

  always_comb begin
    o_state   = r_state;
    o_play_en = (r_state == ST_PLAY);
    o_score0  = r_score.ones;
    o_score1  = r_score.tens;
    o_lives   = r_lives;
  end
endmodule

// File: tb/tb_scoreboard_controller.sv
// Randomized + directed bench for scoreboard_controller against a decimal-score model.
module tb_scoreboard_controller;
  localparam int NREQ = 4;
  localparam int FR   = 6;

  logic clk = 1'b0, reset = 1'b0, vsync = 1'b0, start = 1'b0;
  logic [3:0] score0, score1, lives;
  logic [1:0] state;
  logic       play_en;

  int n_chk = 0, n_fail = 0, cyc = 0, dy_rises = 0, ov_rises = 0;
  int m_score = 0, m_lives = 3, m_ptr = 0;

  scoreboard_controller_if #(.NREQ(NREQ)) bus ();

  scoreboard_controller #(
    .NREQ(NREQ), .START_LIVES(3), .DEATH_FRAMES(60), .OVER_FRAMES(180)
  ) dut (
    .clk(clk), .reset(reset), .i_vsync(vsync), .i_start(start), .bus(bus),
    .o_score0(score0), .o_score1(score1), .o_lives(lives), .o_state(state), .o_play_en(play_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int score_now();
    return int'(score1) * 10 + int'(score0);
  endfunction

  task automatic model_add(input int p);
    m_score = m_score + ((p > 9) ? 9 : p);
    if (m_score > 99) m_score = 99;
  endtask

  // One clock; vsync rises every FR cycles, rises are tallied per sampled state.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if ((cyc % FR) == 0) begin
      if (state == 2'd2) dy_rises++;
      if (state == 2'd3) ov_rises++;
      vsync = 1'b1;
    end else if ((cyc % FR) == 2) begin
      vsync = 1'b0;
    end
  endtask

  task automatic single(input int i, input logic [3:0] p, input string tag);
    int n;
    bus.score_pts[4*i +: 4] = p;
    bus.score_req[i] = 1'b1;
    n = 0;
    do begin step(); n++; end while (bus.score_ack == '0 && n < 50);
    chk({tag, "_ack"}, int'(bus.score_ack), 1 << i);
    model_add(int'(p));
    m_ptr = (i + 1) % NREQ;
    chk({tag, "_score"}, score_now(), m_score);
    bus.score_req[i] = 1'b0;
    step();
    chk({tag, "_ack1cyc"}, int'(bus.score_ack), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    int n, k, seen, exp_i;
    logic [NREQ-1:0] last;
    bus.score_req = '0; bus.score_pts = '0; bus.die_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_score", score_now(), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_ack", int'(bus.score_ack), 0);
    chk("rst_die_ack", int'(bus.die_ack), 0);
    chk("rst_play_en", int'(play_en), 0);
    #2 reset = 1'b1;
    step();
    chk("idle_hold", int'(state), 0);

    pulse_start();
    chk("start_state", int'(state), 1);
    chk("start_score", score_now(), 0);
    chk("start_lives", int'(lives), 3);
    chk("start_play_en", int'(play_en), 1);

    single(0, 4'd7, "s7");
    start = 1'b1; step(); step(); start = 1'b0;
    chk("restart_state", int'(state), 1);
    chk("restart_score", score_now(), 7);
    chk("restart_lives", int'(lives), 3);
    single(3, 4'd5, "s5");
    chk("s12", score_now(), 12);

    // All requesters held; expect rotation 0..3 from pointer 0.
    for (int i = 0; i < NREQ; i++) bus.score_pts[4*i +: 4] = 4'd1;
    bus.score_req = '1;
    k = 0; n = 0;
    while (k < NREQ && n < 40) begin
      step(); n++;
      if (bus.score_ack != '0) begin
        chk($sformatf("rot%0d", k), int'(bus.score_ack), 1 << k);
        bus.score_req = bus.score_req & ~bus.score_ack;
        model_add(1);
        k++;
      end
    end
    chk("rot_done", k, NREQ);
    repeat (3) step();
    chk("rot_quiet", int'(bus.score_ack), 0);
    chk("rot_score", score_now(), 16);

    // die and score in the same cycle
    bus.score_pts[8 +: 4] = 4'd4; bus.score_req[2] = 1'b1; bus.die_req = 1'b1;
    dy_rises = 0;
    step();
    chk("die_ack", int'(bus.die_ack), 1);
    chk("die_noscore", int'(bus.score_ack), 0);
    chk("die_lives", int'(lives), 2);
    chk("die_state", int'(state), 2);
    bus.die_req = 1'b0; m_lives = 2;
    step();
    chk("die_ack1cyc", int'(bus.die_ack), 0);
    n = 0;
    while (state == 2'd2 && n < 3000) begin step(); n++; end
    chk("dying_frames", dy_rises, 60);
    chk("dying_exit", int'(state), 1);
    chk("resume_noack", int'(bus.score_ack), 0);
    step();
    chk("resume_ack", int'(bus.score_ack), 4);
    model_add(4); m_ptr = 3;
    chk("resume_score", score_now(), m_score);
    bus.score_req[2] = 1'b0;
    step();
    chk("resume_ack1cyc", int'(bus.score_ack), 0);

    // Random requesters against the decimal model.
    last = '0; n = 0;
    while (n < 400 && m_score < 85) begin
      step(); n++;
      exp_i = -1;
      for (int j = 0; j < NREQ; j++)
        if (exp_i < 0 && last[(m_ptr + j) % NREQ]) exp_i = (m_ptr + j) % NREQ;
      chk("rr_grant", int'(bus.score_ack), (exp_i < 0) ? 0 : (1 << exp_i));
      if (exp_i >= 0) begin
        model_add(int'(bus.score_pts[4*exp_i +: 4]));
        m_ptr = (exp_i + 1) % NREQ;
      end
      chk("rr_score", score_now(), m_score);
      seen = int'(bus.score_ack);
      bus.score_req = bus.score_req & ~bus.score_ack;
      if (m_score < 85)
        for (int j = 0; j < NREQ; j++)
          if (!bus.score_req[j] && !seen[j] && $urandom_range(0, 2) == 0) begin
            bus.score_pts[4*j +: 4] = 4'($urandom_range(0, 15));
            bus.score_req[j] = 1'b1;
          end
      last = bus.score_req;
    end
    bus.score_req = '0;
    step();
    chk("rr_quiet", int'(bus.score_ack), 0);

    while (m_score < 95) single(1, 4'(((95 - m_score) > 9) ? 9 : (95 - m_score)), "fill");
    chk("at95", score_now(), 95);
    single(1, 4'd12, "sat12");
    chk("sat99", score_now(), 99);
    single(1, 4'd3, "sat3");
    chk("stay99", score_now(), 99);

    // Last lives -> OVER -> IDLE
    bus.die_req = 1'b1; step(); bus.die_req = 1'b0;
    chk("die2_lives", int'(lives), 1);
    n = 0;
    while (state == 2'd2 && n < 3000) begin step(); n++; end
    chk("die2_exit", int'(state), 1);
    bus.die_req = 1'b1; ov_rises = 0;
    step(); bus.die_req = 1'b0;
    chk("over_lives", int'(lives), 0);
    chk("over_state", int'(state), 3);
    chk("over_die_ack", int'(bus.die_ack), 1);
    n = 0;
    while (state == 2'd3 && n < 5000) begin step(); n++; end
    chk("over_frames", ov_rises, 180);
    chk("over_exit", int'(state), 0);
    chk("over_keep_score", score_now(), 99);
    chk("over_keep_lives", int'(lives), 0);
    chk("over_play_en", int'(play_en), 0);
    pulse_start();
    chk("new_state", int'(state), 1);
    chk("new_score", score_now(), 0);
    chk("new_lives", int'(lives), 3);

    // Reset while an ack is high
    bus.score_pts[0 +: 4] = 4'd5; bus.score_req[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (bus.score_ack == '0 && n < 50);
    chk("hs_ack", int'(bus.score_ack), 1);
    #2 reset = 1'b0; #1;
    chk("hs_rst_ack", int'(bus.score_ack), 0);
    chk("hs_rst_score", score_now(), 0);
    chk("hs_rst_state", int'(state), 0);
    #2 reset = 1'b1;
    bus.die_req = 1'b1;
    seen = 0;
    repeat (10) begin step(); if (bus.score_ack != '0 || bus.die_ack) seen++; end
    chk("hs_post_noack", seen, 0);
    chk("hs_post_idle", int'(state), 0);
    bus.die_req = 1'b0; bus.score_req = '0;

    // Reset mid-DYING with a pending request
    pulse_start();
    chk("g3_state", int'(state), 1);
    bus.score_pts[4 +: 4] = 4'd3; bus.score_req[1] = 1'b1; bus.die_req = 1'b1;
    step(); bus.die_req = 1'b0;
    chk("g3_die_ack", int'(bus.die_ack), 1);
    repeat (20) step();
    chk("g3_mid_dying", int'(state), 2);
    chk("g3_lives", int'(lives), 2);
    #2 reset = 1'b0; #1;
    chk("dy_rst_state", int'(state), 0);
    chk("dy_rst_lives", int'(lives), 3);
    chk("dy_rst_score", score_now(), 0);
    chk("dy_rst_play_en", int'(play_en), 0);
    chk("dy_rst_die_ack", int'(bus.die_ack), 0);
    #2 reset = 1'b1;
    seen = 0;
    repeat (10) begin step(); if (bus.score_ack != '0 || bus.die_ack) seen++; end
    chk("dy_post_noack", seen, 0);
    chk("dy_post_idle", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
